status_register: RTL and testbench
==================================

# status_register

Holds the processor's architectural condition flags (Z N C V) and feeds them to the condition tester in the data path. Flags are updated from the ALU under S-bit control, with a per-flag write mask. A same-cycle bypass lets the condition tester see flags being written this cycle. A single saved copy is kept for exception entry and return.

## Interface
- Parameters
  - `RESET_FLAGS`, default 4'b0000: CPSR flag value after reset (order Z N C V).
- Ports
  - `clk` input 1: clock; all state updates on rising edge.
  - `reset` input 1: synchronous, active-high.
  - `alu_flags` input 4: Z N C V from the ALU, bit 3 = Z, bit 2 = N, bit 1 = C, bit 0 = V.
  - `flag_we` input 1: S-bit write request from the instruction in execute.
  - `cond_pass` input 1: condition-tester result for that instruction; the write is qualified by it.
  - `flag_mask` input 4: per-flag write enable, same bit order (logic ops: 4'b1110 or 4'b1100).
  - `exc_entry` input 1: one-cycle pulse; save flags to SPSR.
  - `exc_return` input 1: one-cycle pulse; restore CPSR from SPSR.
  - `flags_out` output 4: registered CPSR.
  - `flags_fwd` output 4: combinational effective flags for the condition tester.
  - `spsr_out` output 4: registered SPSR.
  - `in_exception` output 1: FSM is in EXC.
  - `nest_err` output 1: sticky; set when exception entry or return is illegal.

## Operation
- Write qualifier: `wr = flag_we & cond_pass & ~exc_return`.
- Merge rule, per bit i: `merged[i] = flag_mask[i] ? alu_flags[i] : cpsr[i]`.
- `flags_fwd = wr ? merged : cpsr`. This is the only combinational path. No path from `flags_fwd` back into `cond_pass` may be created outside this block.
- FSM has two states, NORMAL and EXC. Reset state is NORMAL.
  - NORMAL, `exc_entry` asserted:
    - SPSR ← `flags_fwd`, so a same-cycle write is included.
    - CPSR ← merged if `wr`, else unchanged.
    - Next state: EXC.
  - NORMAL, `exc_return` asserted:
    - Illegal. Set `nest_err`.
    - CPSR is not restored, and a same-cycle flag write is still dropped.
    - State stays NORMAL.
  - EXC, `exc_return` asserted:
    - CPSR ← SPSR; any same-cycle flag write is discarded.
    - Next state: NORMAL.
  - EXC, `exc_entry` asserted (nesting is unsupported):
    - Set `nest_err`.
    - SPSR is unchanged; a flag write proceeds normally.
    - State stays EXC.
  - `exc_entry` and `exc_return` asserted together:
    - `exc_return` has priority and `exc_entry` is ignored.
    - This event alone does not set `nest_err`.
- Otherwise CPSR ← merged when `wr`. `flag_mask` = 0 with `wr` = 1 leaves CPSR unchanged.
- `nest_err` clears only on `reset`.

## Timing
- All outputs are registered except `flags_fwd`.
- Flag-write latency: CPSR shows the new value on `flags_out` one cycle after the `wr` edge. `flags_fwd` shows it in the same cycle.
- Restore latency: `flags_out` = SPSR one cycle after the `exc_return` edge.
- Back-to-back writes on consecutive cycles: each merges against the CPSR already updated by the previous write.
- Priority within a cycle: `reset` > `exc_return` > `exc_entry` > flag write.
- Reset values:
  - `flags_out` = `RESET_FLAGS`
  - `spsr_out` = 4'b0000
  - `in_exception` = 0
  - `nest_err` = 0
  - `flags_fwd` = `RESET_FLAGS` once inputs are idle.
- `reset` asserted while in EXC: returns to NORMAL and the SPSR contents are lost. Any other input that cycle is ignored.

## Structure
- The shared package `cpu_defs` holds:
  - the flag bit-index constants `FLAG_Z=3`, `FLAG_N=2`, `FLAG_C=1`, `FLAG_V=0`;
  - the FSM state encoding (NORMAL=1'b0, EXC=1'b1);
  - the mask constants `MASK_ALL=4'b1111` and `MASK_ZN=4'b1100`.
- The condition tester already depends on the same flag order and imports these constants.
- One sub-module, `flag_merge`: the combinational masked merge, instantiated once. Its output is used for both the CPSR write and the SPSR save.

## Test plan
- Reset, then idle:
  - `flags_out`=0000, `spsr_out`=0000, `in_exception`=0, `nest_err`=0.
- Full write:
  - `alu_flags`=1010, `mask`=1111, `flag_we`=1, `cond_pass`=1.
  - Same cycle: `flags_fwd`=1010. Next cycle: `flags_out`=1010.
- Masked and suppressed writes, starting from CPSR=0011:
  - `alu_flags`=1100, `mask`=1100 → CPSR=1111.
  - Then `cond_pass`=0 with `alu_flags`=0000 → CPSR stays 1111 and `flags_fwd`=1111.
- Entry with a same-cycle write, starting from CPSR=0001:
  - `exc_entry`=1 with a write of `alu_flags`=1000, `mask`=1000.
  - Result: SPSR=1001, CPSR=1001, `in_exception`=1.
  - Then write CPSR=0110 and issue `exc_return` together with a write of 1111: CPSR=1001, write dropped, `in_exception`=0.
- Illegal sequencing:
  - `exc_return` in NORMAL → `nest_err`=1, CPSR unchanged.
  - `exc_entry` twice → second entry leaves SPSR unchanged and `nest_err` stays 1.
  - Only `reset` clears `nest_err`.
- Reset mid-exception:
  - In EXC with SPSR=1010, assert `reset` together with `exc_return`.
  - Result: `in_exception`=0, SPSR=0000, CPSR=`RESET_FLAGS`.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared CPU definitions: condition flag bit order, status FSM encoding and
// common flag-write masks.
package cpu_defs;

   localparam int unsigned FLAG_Z = 3;
   localparam int unsigned FLAG_N = 2;
   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_V = 0;

   localparam logic [3:0] MASK_ALL = 4'b1111;
   localparam logic [3:0] MASK_ZN  = 4'b1100;

   typedef enum logic {
      NORMAL = 1'b0,
      EXC    = 1'b1
   } sr_state_e;

endpackage

// File: rtl/flag_merge.sv
// Masked merge of ALU flags into the current CPSR, one mux per flag bit.
module flag_merge
   import cpu_defs::*;
(
   input  logic [3:0] cpsr,
   input  logic [3:0] alu_flags,
   input  logic [3:0] flag_mask,
   output logic [3:0] merged
);

   always_comb begin
      merged = cpsr;
      for (int i = 0; i < 4; i++) begin
         if (flag_mask[i]) merged[i] = alu_flags[i];
      end
   end

endmodule

// File: rtl/status_register.sv
// Architectural condition flags (CPSR) with same-cycle bypass and a single
// saved copy (SPSR) for exception entry/return.
module status_register
   import cpu_defs::*;
#(
   parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] alu_flags,
   input  logic       flag_we,
   input  logic       cond_pass,
   input  logic [3:0] flag_mask,
   input  logic       exc_entry,
   input  logic       exc_return,
   output logic [3:0] flags_out,
   output logic [3:0] flags_fwd,
   output logic [3:0] spsr_out,
   output logic       in_exception,
   output logic       nest_err
);

   sr_state_e  state_q, state_d;
   logic [3:0] cpsr_q, cpsr_d;
   logic [3:0] spsr_q, spsr_d;
   logic       nest_err_q, nest_err_d;
   logic [3:0] merged;
   logic       wr;

   // A return always discards a same-cycle flag write, legal or not.
   assign wr = flag_we & cond_pass & ~exc_return;

   flag_merge u_flag_merge (
      .cpsr      (cpsr_q),
      .alu_flags (alu_flags),
      .flag_mask (flag_mask),
      .merged    (merged)
   );

   assign flags_fwd = wr ? merged : cpsr_q;

   always_comb begin
      state_d    = state_q;
      cpsr_d     = cpsr_q;
      spsr_d     = spsr_q;
      nest_err_d = nest_err_q;
      if (exc_return) begin
         if (state_q == EXC) begin
            cpsr_d  = spsr_q;
            state_d = NORMAL;
         end else begin
            nest_err_d = 1'b1;
         end
      end else begin
         if (wr) cpsr_d = merged;
         if (exc_entry) begin
            if (state_q == NORMAL) begin
               spsr_d  = flags_fwd;
               state_d = EXC;
            end else begin
               nest_err_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= NORMAL;
         cpsr_q     <= RESET_FLAGS;
         spsr_q     <= 4'b0000;
         nest_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cpsr_q     <= cpsr_d;
         spsr_q     <= spsr_d;
         nest_err_q <= nest_err_d;
      end
   end

   assign flags_out    = cpsr_q;
   assign spsr_out     = spsr_q;
   assign in_exception = (state_q == EXC);
   assign nest_err     = nest_err_q;

endmodule

// File: tb/tb_status_register.sv
// Self-checking bench for status_register: directed scenarios followed by
// random traffic, all checked against a cycle-level flag model.
module tb_status_register;

   localparam logic [3:0] RST_FLAGS = 4'b0000;

   logic       clk;
   logic       reset;
   logic [3:0] alu_flags;
   logic       flag_we;
   logic       cond_pass;
   logic [3:0] flag_mask;
   logic       exc_entry;
   logic       exc_return;
   logic [3:0] flags_out;
   logic [3:0] flags_fwd;
   logic [3:0] spsr_out;
   logic       in_exception;
   logic       nest_err;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [3:0] m_cpsr;
   logic [3:0] m_spsr;
   logic       m_exc;
   logic       m_err;

   status_register #(
      .RESET_FLAGS (RST_FLAGS)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .alu_flags    (alu_flags),
      .flag_we      (flag_we),
      .cond_pass    (cond_pass),
      .flag_mask    (flag_mask),
      .exc_entry    (exc_entry),
      .exc_return   (exc_return),
      .flags_out    (flags_out),
      .flags_fwd    (flags_fwd),
      .spsr_out     (spsr_out),
      .in_exception (in_exception),
      .nest_err     (nest_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %b expected %b", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] model_fwd();
      logic [3:0] m;
      logic       w;
      w = flag_we && cond_pass && !exc_return;
      m = (alu_flags & flag_mask) | (m_cpsr & ~flag_mask);
      return w ? m : m_cpsr;
   endfunction

   task automatic model_step();
      logic [3:0] fwd;
      logic       w;
      fwd = model_fwd();
      w   = flag_we && cond_pass && !exc_return;
      if (reset) begin
         m_cpsr = RST_FLAGS;
         m_spsr = 4'b0000;
         m_exc  = 1'b0;
         m_err  = 1'b0;
      end else if (exc_return) begin
         if (m_exc) begin
            m_cpsr = m_spsr;
            m_exc  = 1'b0;
         end else begin
            m_err = 1'b1;
         end
      end else begin
         if (exc_entry) begin
            if (!m_exc) begin
               m_spsr = fwd;
               m_exc  = 1'b1;
            end else begin
               m_err = 1'b1;
            end
         end
         if (w) m_cpsr = fwd;
      end
   endtask

   // One clock cycle: apply inputs, check the bypass mid-cycle, clock, then
   // check every registered output against the model.
   task automatic cycle(input logic rst, input logic [3:0] alu, input logic we,
                        input logic cp, input logic [3:0] mask,
                        input logic ent, input logic ret);
      reset      = rst;
      alu_flags  = alu;
      flag_we    = we;
      cond_pass  = cp;
      flag_mask  = mask;
      exc_entry  = ent;
      exc_return = ret;
      #2;
      check("flags_fwd", flags_fwd, model_fwd());
      @(posedge clk);
      model_step();
      #1;
      check("flags_out", flags_out, m_cpsr);
      check("spsr_out", spsr_out, m_spsr);
      check("in_exception", {3'b000, in_exception}, {3'b000, m_exc});
      check("nest_err", {3'b000, nest_err}, {3'b000, m_err});
   endtask

   task automatic idle();
      cycle(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
   endtask

   task automatic write(input logic [3:0] v);
      cycle(1'b0, v, 1'b1, 1'b1, 4'b1111, 1'b0, 1'b0);
   endtask

   initial begin
      m_cpsr = RST_FLAGS;
      m_spsr = 4'b0000;
      m_exc  = 1'b0;
      m_err  = 1'b0;
      reset = 1'b1; alu_flags = '0; flag_we = 1'b0; cond_pass = 1'b0;
      flag_mask = '0; exc_entry = 1'b0; exc_return = 1'b0;
      @(posedge clk);
      #1;
      cycle(1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
      idle();
      check("reset_flags_out", flags_out, 4'b0000);
      check("reset_spsr", spsr_out, 4'b0000);
      check("reset_in_exc", {3'b000, in_exception}, 4'b0000);
      check("reset_nest_err", {3'b000, nest_err}, 4'b0000);
      check("reset_fwd", flags_fwd, RST_FLAGS);

      // Full write with same-cycle bypass
      write(4'b1010);
      check("full_write", flags_out, 4'b1010);

      // Masked write then suppressed write
      write(4'b0011);
      cycle(1'b0, 4'b1100, 1'b1, 1'b1, 4'b1100, 1'b0, 1'b0);
      check("masked_write", flags_out, 4'b1111);
      cycle(1'b0, 4'b0000, 1'b1, 1'b0, 4'b1111, 1'b0, 1'b0);
      check("cond_fail_cpsr", flags_out, 4'b1111);
      check("cond_fail_fwd", flags_fwd, 4'b1111);
      cycle(1'b0, 4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0);
      check("zero_mask", flags_out, 4'b1111);

      // Entry with same-cycle write, then return dropping a write
      write(4'b0001);
      cycle(1'b0, 4'b1000, 1'b1, 1'b1, 4'b1000, 1'b1, 1'b0);
      check("entry_spsr", spsr_out, 4'b1001);
      check("entry_cpsr", flags_out, 4'b1001);
      check("entry_in_exc", {3'b000, in_exception}, 4'b0001);
      write(4'b0110);
      cycle(1'b0, 4'b1111, 1'b1, 1'b1, 4'b1111, 1'b0, 1'b1);
      check("return_cpsr", flags_out, 4'b1001);
      check("return_in_exc", {3'b000, in_exception}, 4'b0000);

      // Illegal return in NORMAL
      cycle(1'b0, 4'b0110, 1'b1, 1'b1, 4'b1111, 1'b0, 1'b1);
      check("bad_return_err", {3'b000, nest_err}, 4'b0001);
      check("bad_return_cpsr", flags_out, 4'b1001);

      // Double entry
      cycle(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0);
      write(4'b0101);
      cycle(1'b0, 4'b1100, 1'b1, 1'b1, 4'b1100, 1'b1, 1'b0);
      check("nest_spsr", spsr_out, 4'b1001);
      check("nest_cpsr", flags_out, 4'b1101);
      check("nest_err_sticky", {3'b000, nest_err}, 4'b0001);
      cycle(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1);
      idle();
      check("err_survives", {3'b000, nest_err}, 4'b0001);
      cycle(1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
      check("err_cleared", {3'b000, nest_err}, 4'b0000);

      // Reset while in EXC
      write(4'b1010);
      cycle(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0);
      check("exc_spsr", spsr_out, 4'b1010);
      cycle(1'b1, 4'b1111, 1'b1, 1'b1, 4'b1111, 1'b0, 1'b1);
      check("rst_exc_in_exc", {3'b000, in_exception}, 4'b0000);
      check("rst_exc_spsr", spsr_out, 4'b0000);
      check("rst_exc_cpsr", flags_out, RST_FLAGS);

      // Random traffic
      for (int n = 0; n < 600; n++) begin
         cycle(($urandom_range(0, 39) == 0), 4'($urandom), 1'($urandom),
               ($urandom_range(0, 3) != 0), 4'($urandom),
               ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
